// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Register scoreboard and hazard unit for an in-order pipeline that has
// long-latency operations (loads, divides, ...). A pending bit per
// architectural register tracks in-flight long-latency writes. Decode is
// stalled on RAW/WAW hazards against those writes, or when a new
// long-latency op cannot be issued. A small FSM drains all in-flight writes
// for fences and traps.
//
// Optional build macro: HAZARD_SCOREBOARD_PERF_EN
//   defined   -> stall_cycles counts cycles with hazD=1 and halt=0
//                (saturating at 32'hFFFF_FFFF)
//   undefined -> stall_cycles is tied to 0 and no counter is built
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   halt                  freezes the front end (stalls, suppresses bubble)
//   Rs1D, Rs2D, RdD       decode-stage register indices
//   UsesRs1D, UsesRs2D    decode operand-use flags
//   RegWriteD, IsLongD    decode writes rd / decode op is long-latency
//   issue_valid/issue_rd  long-latency op leaving E, marks rd pending
//   cpl_valid/cpl_rd      long-latency writeback, clears rd pending
//   drain_req/drained     fence/trap drain handshake
//   StallF, StallD        fetch and decode stall
//   BubbleE               insert a bubble into E
//   issue_ready           a long-latency op may issue this cycle
//   pending               per-register pending bits
//   outstanding           number of in-flight long-latency writes
//   err                   sticky protocol-error flag
//   stall_cycles          hazard stall performance counter
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NUM_REGS        = 32,
  parameter int REG_AW          = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   halt,
  input  logic [REG_AW-1:0]                      Rs1D,
  input  logic [REG_AW-1:0]                      Rs2D,
  input  logic [REG_AW-1:0]                      RdD,
  input  logic                                   UsesRs1D,
  input  logic                                   UsesRs2D,
  input  logic                                   RegWriteD,
  input  logic                                   IsLongD,
  input  logic                                   issue_valid,
  input  logic [REG_AW-1:0]                      issue_rd,
  input  logic                                   cpl_valid,
  input  logic [REG_AW-1:0]                      cpl_rd,
  input  logic                                   drain_req,
  output logic                                   drained,
  output logic                                   StallF,
  output logic                                   StallD,
  output logic                                   BubbleE,
  output logic                                   issue_ready,
  output logic [NUM_REGS-1:0]                    pending,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   err,
  output logic [31:0]                            stall_cycles
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic [OW-1:0]         outstanding_q, outstanding_d;
  logic                  err_q, err_d;

  logic                  issue_ev, cpl_ev;
  logic                  cpl_ok, cpl_err;
  logic                  issue_ok, issue_err;
  logic                  hazD;

  // A register index stalls a consumer if it is pending (or being issued
  // this cycle when allow_issue is set), unless it is x0 or its value is
  // being written back right now.
  function automatic logic reg_busy(input logic [REG_AW-1:0] idx,
                                    input logic              allow_issue);
    logic busy;
    busy = pending_q[idx] || (allow_issue && issue_valid && (issue_rd == idx));
    if (idx == '0)                      busy = 1'b0;
    if (cpl_valid && (cpl_rd == idx))   busy = 1'b0;
    return busy;
  endfunction

  // ---- scoreboard event qualification ----
  assign issue_ready = (outstanding_q < MAX_CNT) || cpl_valid;

  always_comb begin
    issue_ev  = issue_valid && (issue_rd != '0);
    cpl_ev    = cpl_valid && (cpl_rd != '0);
    cpl_ok    = cpl_ev && pending_q[cpl_rd];
    cpl_err   = cpl_ev && !pending_q[cpl_rd];
    issue_err = 1'b0;
    if (issue_ev) begin
      if (!issue_ready)
        issue_err = 1'b1;
      // Re-issue to a pending rd is legal only if that rd retires this cycle.
      if (pending_q[issue_rd] && !(cpl_ok && (cpl_rd == issue_rd)))
        issue_err = 1'b1;
      // issue_ready may be granted by a completion that turns out to be
      // ignored (rd=0 or not pending); the count must never exceed the cap.
      if ((outstanding_q >= MAX_CNT) && !cpl_ok)
        issue_err = 1'b1;
    end
    issue_ok = issue_ev && !issue_err;
  end

  // ---- next-state of pending / outstanding / err ----
  always_comb begin
    pending_d     = pending_q;
    outstanding_d = outstanding_q;
    err_d         = err_q | issue_err | cpl_err;
    if (cpl_ok)
      pending_d[cpl_rd] = 1'b0;
    // Set after clear so a same-rd issue+completion leaves the bit set.
    if (issue_ok)
      pending_d[issue_rd] = 1'b1;
    if (issue_ok && !cpl_ok)
      outstanding_d = outstanding_q + OW'(1);
    else if (!issue_ok && cpl_ok)
      outstanding_d = outstanding_q - OW'(1);
  end

  // ---- hazard detection ----
  always_comb begin
    hazD = 1'b0;
    if (UsesRs1D && reg_busy(Rs1D, 1'b1))   hazD = 1'b1;
    if (UsesRs2D && reg_busy(Rs2D, 1'b1))   hazD = 1'b1;
    if (RegWriteD && reg_busy(RdD, 1'b0))   hazD = 1'b1;
    if (IsLongD && !issue_ready)            hazD = 1'b1;
  end

  // ---- drain FSM next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (drain_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_req)
          state_d = ST_RUN;
        else if ((outstanding_q == '0) && !issue_valid)
          state_d = ST_DRAINED;
      end
      ST_DRAINED: begin
        if (!drain_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    StallF  = hazD || halt || (state_q != ST_RUN);
    StallD  = StallF;
    BubbleE = (hazD || (state_q == ST_DRAIN)) && !halt;
    drained = (state_q == ST_DRAINED);
  end

  assign pending     = pending_q;
  assign outstanding = outstanding_q;
  assign err         = err_q;

  // ---- state registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pending_q     <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0] stall_cnt_q;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt_q <= 32'd0;
    else if (hazD && !halt)
      stall_cnt_q <= sat_inc32(stall_cnt_q);
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
